plantard_descale: RTL and testbench

//  Streaming exit scaler of the NTT datapath: multiplies each coefficient by constant W mod q via Plantard reduction.

---
 rtl/ntt_pkg.sv | 32 +++
 rtl/plantard_cmul.sv | 48 ++++
 rtl/plantard_descale.sv | 61 ++++++
 tb/tb_plantard_descale.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, types and the Plantard constant helper for the NTT datapath.
package ntt_pkg;
  localparam int unsigned DW = 14;
  localparam int unsigned Q  = 12289;
  localparam int unsigned L  = 15;
  localparam int unsigned N  = 512;
  localparam int unsigned CW = $clog2(N);

  typedef logic [DW-1:0]   coeff_t;
  typedef logic [L-1:0]    half_t;
  typedef logic [2*L-1:0]  wide_t;
  typedef logic [DW+L-1:0] prod_t;
  typedef logic [CW-1:0]   cnt_t;

  // WP = (w * -2^(2L) mod Q) * Q^-1 mod 2^(2L)
  function automatic wide_t plantard_const(input int unsigned w);
    longint unsigned q64;
    longint unsigned mask;
    longint unsigned wneg;
    longint unsigned qinv;
    q64  = 64'(Q);
    mask = (64'd1 << (2 * L)) - 64'd1;
    wneg = (64'(w) * ((64'd1 << (2 * L)) % q64)) % q64;
    wneg = (q64 - wneg) % q64;
    // Newton iteration for Q^-1: every step doubles the count of correct low bits
    qinv = q64;
    for (int i = 0; i < 5; i++) begin
      qinv = (qinv * (64'd2 - q64 * qinv)) & mask;
    end
    return wide_t'((wneg * qinv) & mask);
  endfunction
endpackage

// File: rtl/plantard_cmul.sv
// Four-stage constant multiplier y = a*W mod Q using Plantard reduction; all stages share one enable.
module plantard_cmul
  import ntt_pkg::*;
#(
  parameter int unsigned W = 12265
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  coeff_t a,
  output coeff_t y
);

  localparam wide_t WP    = plantard_const(W);
  localparam half_t WP_HI = WP[2*L-1:L];
  localparam half_t WP_LO = WP[L-1:0];

  prod_t p_hi;
  prod_t p_lo;
  half_t t;
  wide_t m;
  wide_t t_sum;
  half_t r;

  // Only the low 2L bits of the product matter, so p_hi is shifted into that window and truncated
  always_comb begin
    t_sum = wide_t'({p_hi, {L{1'b0}}}) + wide_t'(p_lo);
    r     = half_t'((m + wide_t'(Q)) >> L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_hi <= '0;
      p_lo <= '0;
      t    <= '0;
      m    <= '0;
      y    <= '0;
    end else if (en) begin
      p_hi <= prod_t'(a) * prod_t'(WP_HI);
      p_lo <= prod_t'(a) * prod_t'(WP_LO);
      t    <= half_t'(t_sum >> L);
      m    <= wide_t'(t) * wide_t'(Q);
      // Plantard lands in 0..Q; fold Q back to 0
      y    <= (r == half_t'(Q)) ? '0 : coeff_t'(r);
    end
  end

endmodule

// File: rtl/plantard_descale.sv
// Streaming exit scaler: out = in*W mod Q with valid/ready flow control and per-polynomial framing.
module plantard_descale
  import ntt_pkg::*;
#(
  parameter int unsigned W = 12265
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  coeff_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output coeff_t out_data,
  output logic   out_last,
  output logic   done
);

  localparam int unsigned STAGES = 4;

  logic              adv;
  logic              at_end;
  logic [STAGES-1:0] vld;
  cnt_t              cnt;

  // Whole pipe moves together; bubbles travel with the data
  assign adv       = ~vld[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[STAGES-1];
  assign at_end    = (cnt == cnt_t'(N - 1));
  assign out_last  = out_valid & at_end;
  assign done      = out_valid & out_ready & at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[STAGES-2:0], in_valid};
    end
  end

  // Output handshake counter; wraps naturally because N is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_valid & out_ready) begin
      cnt <= cnt + cnt_t'(1);
    end
  end

  plantard_cmul #(
    .W(W)
  ) u_cmul (
    .clk(clk),
    .rst(rst),
    .en (adv),
    .a  (in_data),
    .y  (out_data)
  );

endmodule

// File: tb/tb_plantard_descale.sv
// Bench for plantard_descale: three instances (W=1, default, Q-1) share stimulus and a queue-based model.
module tb_plantard_descale;
  localparam int QM   = 12289;
  localparam int NP   = 512;
  localparam int WDEF = 12265;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [13:0] in_data;

  logic        rdy1, rdyd, rdym;
  logic        ov1, ovd, ovm;
  logic [13:0] od1, odd, odm;
  logic        ol1, old, olm;
  logic        dn1, dnd, dnm;

  typedef struct {
    int a;
    int cyc;
  } item_t;

  item_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          out_total = 0;
  int          accepted = 0;
  int          phase_done = 0;
  int          first_out = -1;
  int          last_out = -1;
  bit          lat_mode = 1'b1;
  bit          prev_stall = 1'b0;
  logic [13:0] prev_data;
  logic        prev_last;

  always #5 clk = ~clk;

  plantard_descale #(.W(1)) dut_one (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1), .done(dn1));

  plantard_descale dut_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyd), .in_data(in_data),
    .out_valid(ovd), .out_ready(out_ready), .out_data(odd), .out_last(old), .done(dnd));

  plantard_descale #(.W(QM - 1)) dut_neg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdym), .in_data(in_data),
    .out_valid(ovm), .out_ready(out_ready), .out_data(odm), .out_last(olm), .done(dnm));

  function automatic int mulmod(input int a, input int w);
    return int'((longint'(a) * longint'(w)) % longint'(QM));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check just after, commit on posedge, return at next negedge
  task automatic cyc(input logic v, input int d, input logic r);
    item_t e;
    bit    hs;
    bit    acc;
    bool_end_check: begin end
    in_valid  = v;
    in_data   = 14'(d);
    out_ready = r;
    #1;
    if (v) chk("in_range", 32'(in_data < 14'(QM)), 1);
    hs = ovd & out_ready;
    if (prev_stall) begin
      chk("stall_valid", ovd, 1);
      chk("stall_data", odd, prev_data);
      chk("stall_last", old, prev_last);
    end
    chk("out_last", old, 32'(ovd && ((out_total % NP) == NP - 1)));
    chk("done", dnd, 32'(hs && ((out_total % NP) == NP - 1)));
    phase_done += int'(dnd);
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data_w1", od1, mulmod(e.a, 1));
        chk("data_wdef", odd, mulmod(e.a, WDEF));
        chk("data_wneg", odm, mulmod(e.a, QM - 1));
        if (lat_mode) chk("latency", cycle - e.cyc, 4);
      end
      if (first_out < 0) first_out = cycle;
      last_out = cycle;
      out_total++;
    end
    acc        = v & rdyd;
    prev_stall = ovd & ~out_ready;
    prev_data  = odd;
    prev_last  = old;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back('{a: d, cyc: cycle});
      accepted++;
    end
    cycle++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc(1'b0, 0, 1'b1);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_out_valid", ovd, 0);
    chk("rst_out_last", old, 0);
    chk("rst_done", dnd, 0);
    chk("rst_out_data", odd, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", rdyd, 1);
    exp_q.delete();
    out_total  = 0;
    prev_stall = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(negedge clk);
    do_reset();

    // Boundary values, default-constant values and the r==Q fold
    cyc(1'b1, 0, 1'b1);
    cyc(1'b1, 1, 1'b1);
    cyc(1'b1, QM - 1, 1'b1);
    drain();
    cyc(1'b1, 512, 1'b1);
    cyc(1'b1, 1, 1'b1);
    cyc(1'b1, 0, 1'b1);
    drain();
    cyc(1'b1, QM - 1, 1'b1);
    drain();

    // Full input sweep
    for (int a = 0; a < QM; a++) cyc(1'b1, a, 1'b1);
    drain();

    // Two back-to-back frames
    do_reset();
    phase_done = 0;
    first_out  = -1;
    for (int i = 0; i < 2 * NP; i++) cyc(1'b1, int'($urandom_range(QM - 1, 0)), 1'b1);
    drain();
    chk("two_frames_done", phase_done, 2);
    chk("two_frames_gapless", last_out - first_out, 2 * NP - 1);
    chk("two_frames_count", out_total, 2 * NP);

    // Random valid and backpressure
    lat_mode = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      cyc(1'($urandom_range(9, 0) < 7), int'($urandom_range(QM - 1, 0)), 1'($urandom_range(1, 0)));
    end
    drain();
    lat_mode = 1'b1;

    // Reset mid-frame, then a clean frame
    do_reset();
    phase_done = 0;
    n = accepted;
    while (accepted - n < 300 && cycle < 90000) cyc(1'b1, int'($urandom_range(QM - 1, 0)), 1'b1);
    chk("mid_frame_accepts", accepted - n, 300);
    do_reset();
    chk("mid_frame_no_done", phase_done, 0);
    for (int i = 0; i < NP; i++) cyc(1'b1, int'($urandom_range(QM - 1, 0)), 1'b1);
    drain();
    chk("post_reset_done", phase_done, 1);
    chk("post_reset_count", out_total, NP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
